// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator feeding the execute operand
// mux. Each accepted instruction is decoded combinationally into an
// XLEN-wide sign-extended immediate. The immediate, tag and illegal flag are
// then buffered in a 2-entry skid queue with valid/ready on both sides.
//
// Optional feature macro: IMM_GEN_RVC_EN
//   defined   -> types 5 (CI) and 6 (CJ) decode compressed immediates
//   undefined -> types 5 and 6 are treated like reserved type 7
module imm_gen_stage #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef enum logic [2:0] {
        IMM_I   = 3'd0,
        IMM_S   = 3'd1,
        IMM_SB  = 3'd2,
        IMM_UJ  = 3'd3,
        IMM_U   = 3'd4,
        IMM_CI  = 3'd5,
        IMM_CJ  = 3'd6,
        IMM_RSV = 3'd7
    } immType_e;

    immType_e        typeSel;
    logic [31:0]     imm32;
    logic            newIllegal;
    logic [XLEN-1:0] newImm;

    // Slot 0 is always the head entry; slot 1 holds the second entry.
    logic [XLEN-1:0]  headImm_q, headImm_d;
    logic [TAG_W-1:0] headTag_q, headTag_d;
    logic             headIll_q, headIll_d;
    logic [XLEN-1:0]  tailImm_q, tailImm_d;
    logic [TAG_W-1:0] tailTag_q, tailTag_d;
    logic             tailIll_q, tailIll_d;
    logic [1:0]       count_q, count_d;

    logic push;
    logic pop;

    assign typeSel = immType_e'(in_imm_type);

    // Decode the instruction word into a 32-bit sign-extended immediate.
    always_comb begin
        imm32      = 32'd0;
        newIllegal = 1'b0;
        case (typeSel)
            IMM_I:  imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            IMM_S:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            IMM_SB: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            IMM_UJ: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            IMM_U:  imm32 = {in_instr[31:12], 12'd0};
`ifdef IMM_GEN_RVC_EN
            IMM_CI: imm32 = {{26{in_instr[12]}}, in_instr[12], in_instr[6:2]};
            IMM_CJ: imm32 = {{20{in_instr[12]}}, in_instr[12], in_instr[8],
                             in_instr[10:9], in_instr[6], in_instr[7],
                             in_instr[2], in_instr[11], in_instr[5:3], 1'b0};
`endif
            default: begin
                imm32      = 32'd0;
                newIllegal = 1'b1;
            end
        endcase
    end

    // Widen the 32-bit immediate to XLEN by replicating its sign bit.
    always_comb begin
        newImm       = {XLEN{imm32[31]}};
        newImm[31:0] = imm32;
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_imm     = headImm_q;
    assign out_tag     = headTag_q;
    assign out_illegal = headIll_q;

    // Queue next state: shift the tail forward on a pop from full, and write
    // a new entry into the head when that slot is free or draining this cycle.
    always_comb begin
        headImm_d = headImm_q;
        headTag_d = headTag_q;
        headIll_d = headIll_q;
        tailImm_d = tailImm_q;
        tailTag_d = tailTag_q;
        tailIll_d = tailIll_q;
        count_d   = count_q;

        if (pop && (count_q == 2'd2)) begin
            headImm_d = tailImm_q;
            headTag_d = tailTag_q;
            headIll_d = tailIll_q;
        end

        if (push) begin
            if ((count_q == 2'd0) || pop) begin
                headImm_d = newImm;
                headTag_d = in_tag;
                headIll_d = newIllegal;
            end else begin
                tailImm_d = newImm;
                tailTag_d = in_tag;
                tailIll_d = newIllegal;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Queue state registers; reset empties the queue and zeroes the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headImm_q <= '0;
            headTag_q <= '0;
            headIll_q <= 1'b0;
            tailImm_q <= '0;
            tailTag_q <= '0;
            tailIll_q <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            headImm_q <= headImm_d;
            headTag_q <= headTag_d;
            headIll_q <= headIll_d;
            tailImm_q <= tailImm_d;
            tailTag_q <= tailTag_d;
            tailIll_q <= tailIll_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate generation stage between instruction fetch/decode and the execute operand mux.
- Takes a 32-bit instruction word, a 3-bit immediate type and a pass-through tag. Produces an XLEN-wide sign-extended immediate.
- Buffered in a 2-entry skid queue with valid/ready handshakes on both sides.
- Sustains one instruction per cycle under no back-pressure; never drops or duplicates an entry under back-pressure.

Parameters:
- XLEN, 64, immediate output width; legal values 32 or 64.
- TAG_W, 8, width of the opaque tag carried alongside each instruction (e.g. ROB/PC index).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_instr  input  32  instruction word.
- in_imm_type  input  3  0=I, 1=S, 2=SB, 3=UJ, 4=U, 5=CI, 6=CJ, 7=reserved.
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head entry.
- out_imm  output  XLEN  generated immediate.
- out_tag  output  TAG_W  tag of the head entry.
- out_illegal  output  1  head entry had an unsupported imm_type.

Behaviour:
- Reset: asserting rst_n low immediately clears the queue.
  - out_valid=0, out_imm=0, out_tag=0, out_illegal=0, in_ready=1.
  - Any entry in flight is discarded. No handshake completes while rst_n is low.
- Immediate formats, sign bit always instr[31], all sign-extended to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - SB: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - UJ: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}. With XLEN=64, bits 63:32 = instr[31].
- Immediate generation is combinational on the input side. The result is written into the queue together with the tag and the illegal flag.
- Queue: 2 entries, count 0..2.
  - in_ready = (count != 2). Registered decode, not combinational from out_ready.
  - out_valid = (count != 0). out_imm, out_tag and out_illegal always present the head entry and are held stable while out_valid=1 and out_ready=0.
  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
  - Push only: count+1. Pop only: count-1. Both at count=1: count stays 1, the new entry becomes head on the next cycle. Neither: no change.
- Latency: an entry accepted at edge N is visible on the outputs after edge N (one cycle). Ordering is strictly FIFO.
- Full: count=2 gives in_ready=0, and in_valid is ignored. A pop at count=2 leaves count=1; in_ready rises the following cycle.
- Empty: count=0 gives out_valid=0. Output data is don't-care but held at the last popped value.
- Reserved type 7: out_imm=0, out_illegal=1. The entry still flows through the queue normally.
- in_instr, in_imm_type and in_tag are sampled only on a push. Upstream changes while in_ready=0 have no effect.

Optional Feature:
- Macro: IMM_GEN_RVC_EN.
- Defined: types 5 and 6 decode compressed immediates from instr[15:0], sign-extended to XLEN.
  - CI: {instr[12], instr[6:2]}.
  - CJ: {instr[12], instr[8], instr[10:9], instr[6], instr[7], instr[2], instr[11], instr[5:3], 0}.
- Undefined: types 5 and 6 behave like type 7 (out_imm=0, out_illegal=1). No RVC decode logic is synthesised.

Test Plan:
- XLEN=64, push instr 0xFFF00093 with type I and tag 0x11, out_ready=1 -> one cycle later out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, out_tag=0x11, out_illegal=0.
- Push 0xFE112E23 (S) then 0x80000037 (U) back-to-back -> out_imm=0xFFFFFFFFFFFFFFFC, then 0xFFFFFFFF80000000 on consecutive cycles. With XLEN=32 the same pair gives 0xFFFFFFFC, then 0x80000000.
- Hold out_ready=0 and push 3 entries -> in_ready drops after the 2nd accept, and the 3rd is held upstream. Raise out_ready -> all 3 entries emerge in order with no loss or duplication.
- Push with type 7 -> out_imm=0, out_illegal=1. With IMM_GEN_RVC_EN undefined, type 5 behaves the same way.
- With IMM_GEN_RVC_EN defined, push 0x000010FD with type CI -> out_imm=all ones (-1), out_illegal=0.
- Fill the queue to 2, then pulse rst_n low mid-cycle -> out_valid=0 and in_ready=1 immediately (asynchronous). After release, the first new push is output with no stale data.
